fpalu_div: RTL and testbench

Iterative IEEE-754 single-precision divider. It computes quotient = a_in / b_in using restoring mantissa division, one quotient bit per cycle, and is the inverse companion to the FP32 multiplier in the same FPALU. Special operands (zero, inf, NaN) are resolved early. Flags are produced with the result and a one-cycle done strobe.

---
 rtl/fpalu_div.sv | 227 ++++++++++++++++++++++
 tb/tb_fpalu_div.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpalu_div.sv
// Iterative FP32 divider: restoring mantissa division, one quotient bit per cycle.
// Special operands resolve in CHECK; normal results round half-up in ROUND.
module fpalu_div #(
    parameter int QBITS = 26
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic        enable_in,
    output logic [31:0] quotient,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        DIVIDE = 2'd2,
        ROUND  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]       a_reg;
    logic [31:0]       b_reg;
    logic [24:0]       rem;
    logic [23:0]       dvs;
    logic signed [9:0] exp_r;
    logic [4:0]        cnt;
    logic [QBITS-1:0]  qreg;

    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [22:0] fa;
    logic [22:0] fb;
    logic        sign;
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;
    logic        a_zero;
    logic        b_zero;
    logic        special;
    logic [31:0] spec_q;
    logic        spec_dbz;
    logic signed [9:0] exp_init;

    assign ea   = a_reg[30:23];
    assign eb   = b_reg[30:23];
    assign fa   = a_reg[22:0];
    assign fb   = b_reg[22:0];
    assign sign = a_reg[31] ^ b_reg[31];

    // A zero exponent field means zero: denormal inputs are flushed.
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);

    assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    assign exp_init = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

    always_comb begin
        spec_q   = 32'd0;
        spec_dbz = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_q = 32'h7FC0_0000;
        end else if (a_inf) begin
            spec_q = {sign, 8'hFF, 23'd0};
        end else if (b_inf) begin
            spec_q = {sign, 31'd0};
        end else if (b_zero) begin
            spec_q   = {sign, 8'hFF, 23'd0};
            spec_dbz = 1'b1;
        end else if (a_zero) begin
            spec_q = {sign, 31'd0};
        end
    end

    // One restoring step; rem stays below 2*dvs so the shifted value fits 25 bits.
    logic [24:0] dvs_ext;
    logic        rem_ge;
    logic [24:0] rem_sub;

    assign dvs_ext = {1'b0, dvs};
    assign rem_ge  = (rem >= dvs_ext);
    assign rem_sub = rem_ge ? (rem - dvs_ext) : rem;

    logic [23:0]       mant_pre;
    logic              guard;
    logic signed [9:0] exp_norm;
    logic [24:0]       mant_sum;
    logic [22:0]       frac_fin;
    logic signed [9:0] exp_fin;
    logic [31:0]       round_q;
    logic              round_ov;
    logic              round_uf;

    always_comb begin
        mant_pre = 24'd0;
        guard    = 1'b0;
        exp_norm = exp_r;
        mant_sum = 25'd0;
        frac_fin = 23'd0;
        exp_fin  = exp_r;
        round_q  = 32'd0;
        round_ov = 1'b0;
        round_uf = 1'b0;

        if (qreg[QBITS-1]) begin
            mant_pre = qreg[QBITS-1:QBITS-24];
            guard    = qreg[QBITS-25];
            exp_norm = exp_r;
        end else begin
            mant_pre = qreg[QBITS-2:QBITS-25];
            guard    = qreg[QBITS-26];
            exp_norm = exp_r - 10'sd1;
        end

        mant_sum = {1'b0, mant_pre} + {24'd0, guard};
        if (mant_sum[24]) begin
            frac_fin = mant_sum[23:1];
            exp_fin  = exp_norm + 10'sd1;
        end else begin
            frac_fin = mant_sum[22:0];
            exp_fin  = exp_norm;
        end

        if (exp_fin >= 10'sd255) begin
            round_q  = {sign, 8'hFF, 23'd0};
            round_ov = 1'b1;
        end else if (exp_fin <= 10'sd0) begin
            round_q  = {sign, 31'd0};
            round_uf = 1'b1;
        end else begin
            round_q = {sign, exp_fin[7:0], frac_fin};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable_in) state_next = CHECK;
            CHECK:   state_next = special ? IDLE : DIVIDE;
            DIVIDE:  if (cnt == 5'd1) state_next = ROUND;
            ROUND:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy stays up through the done cycle; it drops only on an IDLE edge with no new start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_reg       <= 32'd0;
            b_reg       <= 32'd0;
            rem         <= 25'd0;
            dvs         <= 24'd0;
            exp_r       <= 10'sd0;
            cnt         <= 5'd0;
            qreg        <= '0;
            quotient    <= 32'd0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= enable_in;
                    if (enable_in) begin
                        a_reg       <= a_in;
                        b_reg       <= b_in;
                        overflow    <= 1'b0;
                        underflow   <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                CHECK: begin
                    if (special) begin
                        quotient    <= spec_q;
                        div_by_zero <= spec_dbz;
                        done        <= 1'b1;
                    end else begin
                        rem   <= {2'b01, fa};
                        dvs   <= {1'b1, fb};
                        exp_r <= exp_init;
                        cnt   <= 5'(QBITS);
                        qreg  <= '0;
                    end
                end
                DIVIDE: begin
                    qreg <= {qreg[QBITS-2:0], rem_ge};
                    rem  <= rem_sub << 1;
                    cnt  <= cnt - 5'd1;
                end
                ROUND: begin
                    quotient  <= round_q;
                    overflow  <= round_ov;
                    underflow <= round_uf;
                    done      <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpalu_div.sv
// Scoreboard bench for fpalu_div: directed vectors plus random operands checked
// against an arithmetic reference model of the FP32 divide rules.
module tb_fpalu_div;

    logic        clock;
    logic        reset;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        enable_in;
    logic [31:0] quotient;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;
    logic        busy;
    logic        done;

    fpalu_div dut (
        .clock       (clock),
        .reset       (reset),
        .a_in        (a_in),
        .b_in        (b_in),
        .enable_in   (enable_in),
        .quotient    (quotient),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // lat counts edges from the accept edge to the edge that raises done.
    typedef struct {
        logic [31:0] q;
        logic        ov;
        logic        uf;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   busy_run = 0;
    logic prev_done = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] q, input logic ov, input logic uf,
                                input logic dz, input int lat);
        exp_t e;
        e.q = q; e.ov = ov; e.uf = uf; e.dz = dz; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    // Reference: integer long division of the hidden-bit mantissas, then the
    // normalise / half-up / range rules applied in plain arithmetic.
    function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        int     ea, eb, ex;
        longint ma, mb, q, m, g;
        logic   s;
        bit     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        e = mk(32'd0, 1'b0, 1'b0, 1'b0, 1);
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) e.q = 32'h7FC00000;
        else if (a_inf)  e.q = {s, 8'hFF, 23'd0};
        else if (b_inf)  e.q = {s, 31'd0};
        else if (b_zero) begin e.q = {s, 8'hFF, 23'd0}; e.dz = 1'b1; end
        else if (a_zero) e.q = {s, 31'd0};
        else begin
            e.lat = 28;
            ma = longint'(a[22:0]) + 8388608;
            mb = longint'(b[22:0]) + 8388608;
            q  = (ma * 33554432) / mb;
            ex = ea - eb + 127;
            if (q >= 33554432) begin
                m = q / 4;
                g = (q / 2) % 2;
            end else begin
                m = q / 2;
                g = q % 2;
                ex = ex - 1;
            end
            m = m + g;
            if (m >= 16777216) begin
                m  = m / 2;
                ex = ex + 1;
            end
            if (ex >= 255) begin
                e.q = {s, 8'hFF, 23'd0}; e.ov = 1'b1;
            end else if (ex <= 0) begin
                e.q = {s, 31'd0}; e.uf = 1'b1;
            end else begin
                e.q = {s, ex[7:0], m[22:0]};
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  ex;
        logic [31:0] fr;
        int          r;
        r  = $urandom_range(0, 15);
        fr = $urandom;
        case (r)
            0:       ex = 8'h00;
            1:       ex = 8'hFF;
            2:       begin ex = 8'hFF; fr = 32'd0; end
            3:       ex = 8'($urandom_range(1, 254));
            4:       begin ex = 8'($urandom_range(100, 154)); fr = 32'd0; end
            default: ex = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom_range(0, 1)), ex, fr[22:0]};
    endfunction

    // Monitor: pops one expectation per done pulse and checks result, timing and busy span.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                checkOutput("done_width", {31'd0, prev_done}, 32'd0);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("quotient", quotient, e.q);
                    checkOutput("overflow", {31'd0, overflow}, {31'd0, e.ov});
                    checkOutput("underflow", {31'd0, underflow}, {31'd0, e.uf});
                    checkOutput("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                    checkOutput("latency", 32'(cyc - e.acc), 32'(e.lat));
                    checkOutput("busy_cycles", 32'(busy_run), 32'(e.lat + 1));
                end
                busy_run = 0;
            end
            prev_done = done;
        end
    end

    // Called at a negedge with the DUT able to accept; returns at the negedge after the accept edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input exp_t e, input bit push);
        a_in      = a;
        b_in      = b;
        enable_in = 1'b1;
        @(posedge clock);
        @(negedge clock);
        enable_in = 1'b0;
        if (push) begin
            e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!busy) return;
        end
        checkOutput("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic waitDone();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (done) return;
        end
        checkOutput("done_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        reset     = 1'b0;
        enable_in = 1'b0;
        a_in      = 32'd0;
        b_in      = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_quotient", quotient, 32'd0);
        checkOutput("reset_flags", {28'd0, overflow, underflow, div_by_zero, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        $display("[TB] directed vectors");
        applyStimulus(32'h40C00000, 32'h40000000, mk(32'h40400000, 0, 0, 0, 28), 1); waitIdle();
        applyStimulus(32'h3F800000, 32'h40400000, mk(32'h3EAAAAAB, 0, 0, 0, 28), 1); waitIdle();
        applyStimulus(32'hC0F00000, 32'h40200000, mk(32'hC0400000, 0, 0, 0, 28), 1); waitIdle();
        applyStimulus(32'h3F800000, 32'h00000000, mk(32'h7F800000, 0, 0, 1, 1), 1);  waitIdle();
        applyStimulus(32'h00000000, 32'h00000000, mk(32'h7FC00000, 0, 0, 0, 1), 1);  waitIdle();
        applyStimulus(32'h7F800000, 32'h3F800000, mk(32'h7F800000, 0, 0, 0, 1), 1);  waitIdle();
        applyStimulus(32'h3F800000, 32'hFF800000, mk(32'h80000000, 0, 0, 0, 1), 1);  waitIdle();
        applyStimulus(32'h7F800000, 32'hFF800000, mk(32'h7FC00000, 0, 0, 0, 1), 1);  waitIdle();
        applyStimulus(32'h7FC00001, 32'h3F800000, mk(32'h7FC00000, 0, 0, 0, 1), 1);  waitIdle();
        applyStimulus(32'h7F000000, 32'h3E800000, mk(32'h7F800000, 1, 0, 0, 28), 1); waitIdle();
        applyStimulus(32'h00800000, 32'h40000000, mk(32'h00000000, 0, 1, 0, 28), 1); waitIdle();

        $display("[TB] enable toggling while busy");
        applyStimulus(32'h40C00000, 32'h40000000, mk(32'h40400000, 0, 0, 0, 28), 1);
        for (int i = 0; i < 12; i++) begin
            enable_in = ~enable_in;
            a_in      = $urandom;
            b_in      = $urandom;
            @(negedge clock);
        end
        enable_in = 1'b0;
        waitIdle();

        $display("[TB] back-to-back accept in the done cycle");
        applyStimulus(32'h3F800000, 32'h40400000, mk(32'h3EAAAAAB, 0, 0, 0, 28), 1);
        waitDone();
        applyStimulus(32'hC0F00000, 32'h40200000, mk(32'hC0400000, 0, 0, 0, 28), 1);
        waitDone();
        applyStimulus(32'h3F800000, 32'h00000000, mk(32'h7F800000, 0, 0, 1, 1), 1);
        waitIdle();

        $display("[TB] reset during divide");
        applyStimulus(32'h40C00000, 32'h40000000, mk(32'h40400000, 0, 0, 0, 28), 0);
        repeat (10) @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("abort_quotient", quotient, 32'd0);
        checkOutput("abort_flags", {28'd0, overflow, underflow, div_by_zero, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("abort_no_done", {31'd0, done}, 32'd0);
        applyStimulus(32'h40C00000, 32'h40000000, mk(32'h40400000, 0, 0, 0, 28), 1); waitIdle();

        $display("[TB] random operands");
        for (int i = 0; i < 60; i++) begin
            ra = rand_fp();
            rb = rand_fp();
            applyStimulus(ra, rb, ref_model(ra, rb), 1);
            if (i % 4 == 3) waitDone();
            else            waitIdle();
        end
        waitIdle();

        repeat (5) @(negedge clock);
        checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
